// File: rtl/i2s_volume_ctrl.sv
// I2S volume stage: oversamples a 64fs I2S stream on the audio master clock,
// scales each 24-bit sample by vol/16 and reserializes it with identical framing.
module i2s_volume_ctrl #(
  parameter int VOL_DEFAULT = 16,
  parameter int VOL_MAX     = 16
) (
  input  logic       AMCLK_i,
  input  logic       reset_n,
  input  logic       ASCLK_i,
  input  logic       ALRCLK_i,
  input  logic       ASDATA_i,
  input  logic       vol_up_i,
  input  logic       vol_down_i,
  output logic       ASCLK_o,
  output logic       ALRCLK_o,
  output logic       ASDATA_o,
  output logic [4:0] vol_o
);

  localparam int NSYNC = 5;

  logic [NSYNC-1:0] async_in;
  logic [NSYNC-1:0] sync_bits;

  assign async_in = {vol_down_i, vol_up_i, ASDATA_i, ALRCLK_i, ASCLK_i};

  generate
    for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge AMCLK_i) begin
        if (!reset_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_bits[gi] = sync_reg;
    end
  endgenerate

  logic bck_s, ws_s, data_s, up_s, dn_s;
  logic bck_d, up_d, dn_d;
  logic bck_rise, bck_fall;

  assign {dn_s, up_s, data_s, ws_s, bck_s} = sync_bits;

  always_ff @(posedge AMCLK_i) begin
    if (!reset_n) begin
      bck_d <= 1'b0;
      up_d  <= 1'b0;
      dn_d  <= 1'b0;
    end else begin
      bck_d <= bck_s;
      up_d  <= up_s;
      dn_d  <= dn_s;
    end
  end

  assign bck_rise = bck_s & ~bck_d;
  assign bck_fall = ~bck_s & bck_d;

  // Volume: edge pulses are registered, so the update lands 4 cycles after the pin edge
  logic       up_pulse_reg, dn_pulse_reg;
  logic [4:0] vol_reg;

  always_ff @(posedge AMCLK_i) begin
    if (!reset_n) begin
      up_pulse_reg <= 1'b0;
      dn_pulse_reg <= 1'b0;
      vol_reg      <= 5'(VOL_DEFAULT);
    end else begin
      up_pulse_reg <= up_s & ~up_d;
      dn_pulse_reg <= dn_s & ~dn_d;
      if (up_pulse_reg && !dn_pulse_reg && vol_reg < 5'(VOL_MAX))
        vol_reg <= vol_reg + 5'd1;
      else if (dn_pulse_reg && !up_pulse_reg && vol_reg != 5'd0)
        vol_reg <= vol_reg - 5'd1;
    end
  end

  assign vol_o = vol_reg;

  logic [5:0]         in_cnt_reg, in_cnt_next;
  logic               ws_last_reg;
  logic [23:0]        in_sr_reg;
  logic               done_reg;
  logic [23:0]        l_q_reg, r_q_reg;
  logic signed [27:0] sample_ext, vol_ext, prod;
  logic [23:0]        scaled;

  // Counter parks at 63 when WS stops toggling, so a stalled stream never completes a word
  always_comb begin
    in_cnt_next = in_cnt_reg;
    if (ws_s != ws_last_reg)
      in_cnt_next = 6'd0;
    else if (in_cnt_reg != 6'd63)
      in_cnt_next = in_cnt_reg + 6'd1;
  end

  assign sample_ext = {{4{in_sr_reg[23]}}, in_sr_reg};
  assign vol_ext    = {23'd0, vol_reg};
  assign prod       = sample_ext * vol_ext;
  assign scaled     = 24'(prod >>> 4);

  always_ff @(posedge AMCLK_i) begin
    if (!reset_n) begin
      in_cnt_reg  <= 6'd63;
      ws_last_reg <= 1'b0;
      in_sr_reg   <= 24'd0;
      done_reg    <= 1'b0;
      l_q_reg     <= 24'd0;
      r_q_reg     <= 24'd0;
    end else begin
      done_reg <= 1'b0;
      if (bck_rise) begin
        in_cnt_reg  <= in_cnt_next;
        ws_last_reg <= ws_s;
        if (in_cnt_next >= 6'd1 && in_cnt_next <= 6'd24)
          in_sr_reg <= {in_sr_reg[22:0], data_s};
        if (in_cnt_next == 6'd25)
          done_reg <= 1'b1;
      end
      if (done_reg) begin
        if (ws_last_reg)
          r_q_reg <= scaled;
        else
          l_q_reg <= scaled;
      end
    end
  end

  logic [31:0] out_sr_reg;
  logic        ws_fall_last_reg;

  always_ff @(posedge AMCLK_i) begin
    if (!reset_n) begin
      ASCLK_o          <= 1'b0;
      ALRCLK_o         <= 1'b0;
      ASDATA_o         <= 1'b0;
      out_sr_reg       <= 32'd0;
      ws_fall_last_reg <= 1'b0;
    end else begin
      ASCLK_o  <= bck_s;
      ALRCLK_o <= ws_s;
      if (bck_fall) begin
        ws_fall_last_reg <= ws_s;
        if (ws_s != ws_fall_last_reg) begin
          out_sr_reg <= {(ws_s ? r_q_reg : l_q_reg), 8'h00};
          ASDATA_o   <= 1'b0;
        end else begin
          ASDATA_o   <= out_sr_reg[31];
          out_sr_reg <= {out_sr_reg[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_volume_ctrl.sv
// Directed bench for i2s_volume_ctrl: drives 64fs I2S frames at AMCLK = 8x BCK and
// decodes the output stream with an independent I2S receiver.
module tb_i2s_volume_ctrl;

  logic       AMCLK_i = 1'b0;
  logic       reset_n;
  logic       ASCLK_i, ALRCLK_i, ASDATA_i;
  logic       vol_up_i, vol_down_i;
  logic       ASCLK_o, ALRCLK_o, ASDATA_o;
  logic [4:0] vol_o;

  i2s_volume_ctrl #(.VOL_DEFAULT(16), .VOL_MAX(16)) dut (
    .AMCLK_i   (AMCLK_i),
    .reset_n   (reset_n),
    .ASCLK_i   (ASCLK_i),
    .ALRCLK_i  (ALRCLK_i),
    .ASDATA_i  (ASDATA_i),
    .vol_up_i  (vol_up_i),
    .vol_down_i(vol_down_i),
    .ASCLK_o   (ASCLK_o),
    .ALRCLK_o  (ALRCLK_o),
    .ASDATA_o  (ASDATA_o),
    .vol_o     (vol_o)
  );

  always #5 AMCLK_i = ~AMCLK_i;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          lag_err   = 0;
  int          pad_err   = 0;
  int          stall_err = 0;
  bit          chk_en    = 1'b0;
  logic [3:0]  bck_hist  = 4'd0;
  logic [3:0]  ws_hist   = 4'd0;
  logic [23:0] out_l, out_r;
  logic [23:0] msr = 24'd0;
  int          mcnt = 63;
  logic        mon_ws_last  = 1'b0;
  logic        mon_bck_prev = 1'b0;

  // Output monitor: 3-cycle lag check on BCK/WS and an I2S receiver on the output pins
  always @(negedge AMCLK_i) begin
    bck_hist = {bck_hist[2:0], ASCLK_i};
    ws_hist  = {ws_hist[2:0], ALRCLK_i};
    if (chk_en && (ASCLK_o !== bck_hist[3] || ALRCLK_o !== ws_hist[3]))
      lag_err++;
    if (ASCLK_o === 1'b1 && mon_bck_prev === 1'b0) begin
      if (ALRCLK_o !== mon_ws_last) mcnt = 0;
      else if (mcnt != 63) mcnt++;
      mon_ws_last = ALRCLK_o;
      if (mcnt >= 1 && mcnt <= 24)
        msr = {msr[22:0], ASDATA_o};
      else if (chk_en && mcnt <= 31 && ASDATA_o !== 1'b0)
        pad_err++;
      if (mcnt == 24) begin
        if (mon_ws_last) out_r = msr;
        else             out_l = msr;
      end
    end
    mon_bck_prev = ASCLK_o;
  end

  task automatic tick();
    @(posedge AMCLK_i);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_out();
    out_l = 'x;
    out_r = 'x;
  endtask

  task automatic send_slot(input logic ws, input logic [23:0] w, input bit rst_mid);
    for (int k = 0; k < 32; k++) begin
      ASCLK_i = 1'b0;
      if (k == 0) ALRCLK_i = ws;
      if (k >= 1 && k <= 24) ASDATA_i = w[24-k];
      else                   ASDATA_i = 1'b0;
      if (rst_mid && k == 12) begin
        chk_en  = 1'b0;
        reset_n = 1'b0;
        tick();
        check("midrst_asclk",  {31'd0, ASCLK_o},  32'd0);
        check("midrst_alrclk", {31'd0, ALRCLK_o}, 32'd0);
        check("midrst_asdata", {31'd0, ASDATA_o}, 32'd0);
        check("midrst_vol",    {27'd0, vol_o},    32'd16);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk_en = 1'b1;
      end
      repeat (4) tick();
      ASCLK_i = 1'b1;
      repeat (4) tick();
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, l, 1'b0);
    send_slot(1'b1, r, 1'b0);
  endtask

  task automatic press(input logic up, input logic dn);
    vol_up_i   = up;
    vol_down_i = dn;
    repeat (6) tick();
    vol_up_i   = 1'b0;
    vol_down_i = 1'b0;
    repeat (6) tick();
  endtask

  task automatic check_words(input string tag, input logic [23:0] l, input logic [23:0] r);
    check({tag, "_L"}, {8'd0, out_l}, {8'd0, l});
    check({tag, "_R"}, {8'd0, out_r}, {8'd0, r});
  endtask

  initial begin
    reset_n    = 1'b0;
    ASCLK_i    = 1'b1;
    ALRCLK_i   = 1'b1;
    ASDATA_i   = 1'b0;
    vol_up_i   = 1'b0;
    vol_down_i = 1'b0;
    repeat (5) tick();
    check("rst_asclk",  {31'd0, ASCLK_o},  32'd0);
    check("rst_alrclk", {31'd0, ALRCLK_o}, 32'd0);
    check("rst_asdata", {31'd0, ASDATA_o}, 32'd0);
    check("rst_vol",    {27'd0, vol_o},    32'd16);
    reset_n = 1'b1;
    repeat (6) tick();
    chk_en = 1'b1;

    // Unity gain pass-through, one frame of latency
    send_frame(24'h123456, 24'hFEDCBA);
    clear_out();
    send_frame(24'h123456, 24'hFEDCBA);
    check_words("unity", 24'h123456, 24'hFEDCBA);
    check("unity_lag", lag_err, 32'd0);

    // Half gain; the word captured before the change keeps the old gain
    repeat (8) press(1'b0, 1'b1);
    check("vol_half", {27'd0, vol_o}, 32'd8);
    clear_out();
    send_frame(24'h400000, 24'hC00000);
    check_words("held", 24'h123456, 24'hFEDCBA);
    clear_out();
    send_frame(24'h000003, 24'h000003);
    check_words("half", 24'h200000, 24'hE00000);
    clear_out();
    send_frame(24'h000000, 24'h000000);
    check_words("half_odd", 24'h000001, 24'h000001);

    // Button latency, saturation, simultaneous edges, mute
    vol_up_i = 1'b1;
    repeat (3) tick();
    check("vol_lat3", {27'd0, vol_o}, 32'd8);
    tick();
    check("vol_lat4", {27'd0, vol_o}, 32'd9);
    vol_up_i = 1'b0;
    repeat (6) tick();
    repeat (20) press(1'b1, 1'b0);
    check("vol_sat_hi", {27'd0, vol_o}, 32'd16);
    repeat (17) press(1'b0, 1'b1);
    check("vol_sat_lo", {27'd0, vol_o}, 32'd0);
    press(1'b1, 1'b0);
    check("vol_one", {27'd0, vol_o}, 32'd1);
    press(1'b1, 1'b1);
    check("vol_both", {27'd0, vol_o}, 32'd1);
    press(1'b0, 1'b1);
    check("vol_zero", {27'd0, vol_o}, 32'd0);
    clear_out();
    send_frame(24'h7FFFFF, 24'h800000);
    clear_out();
    send_frame(24'h123456, 24'h123456);
    check_words("mute", 24'h000000, 24'h000000);

    // Channel ordering with extreme values
    repeat (16) press(1'b1, 1'b0);
    check("vol_back", {27'd0, vol_o}, 32'd16);
    clear_out();
    send_frame(24'h7FFFFF, 24'h800000);
    check_words("mute_held", 24'h000000, 24'h000000);
    for (int i = 0; i < 3; i++) begin
      clear_out();
      send_frame(24'h7FFFFF, 24'h800000);
      check_words("order", 24'h7FFFFF, 24'h800000);
    end

    // Reset at BCK 12 of a left slot: the partial word is dropped
    send_slot(1'b0, 24'hAAAAAA, 1'b1);
    send_slot(1'b1, 24'h555555, 1'b0);
    clear_out();
    send_frame(24'h111111, 24'h222222);
    check_words("postrst", 24'h000000, 24'h555555);
    clear_out();
    send_frame(24'h333333, 24'h444444);
    check_words("postrst2", 24'h111111, 24'h222222);

    // WS held high for 100 BCK with random data
    for (int k = 0; k < 100; k++) begin
      ASCLK_i  = 1'b0;
      ASDATA_i = 1'($urandom);
      repeat (4) begin
        tick();
        if (ASDATA_o !== 1'b0) stall_err++;
      end
      ASCLK_i = 1'b1;
      repeat (4) begin
        tick();
        if (ASDATA_o !== 1'b0) stall_err++;
      end
    end
    check("stall_quiet", stall_err, 32'd0);
    clear_out();
    send_frame(24'h666666, 24'h777777);
    check_words("stall_resume", 24'h333333, 24'h444444);
    clear_out();
    send_frame(24'h000000, 24'h000000);
    check_words("stall_next", 24'h666666, 24'h777777);

    check("lag_total", lag_err, 32'd0);
    check("pad_total", pad_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
